alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 8-bit ALU between two requesters (r0, r1) with valid/ready handshakes.
//  Arbitrates, captures operands, drives the ALU for a fixed number of settle cycles, latches and masks its outputs,
//  and returns the response to the granted requester.
//  Sits between the issue logic and the ALU instance; the ALU itself stays external and combinational.
// PARAMETERS
//  EXEC_CYCLES  1  cycles ALU inputs are held before outputs are latched (1..15)
//  FIXED_PRIO   0  0 = round-robin between r0/r1; 1 = r0 always wins
// PORTS
//  clk_i            in   1  clock, all state on rising edge
//  rst_n_i          in   1  asynchronous, active-low reset
//  r0_req_valid_i   in   1  r0 request valid
//  r0_req_ready_o   out  1  r0 request accepted this cycle
//  r0_opcode_i      in   3  r0 ALU opcode (000 and,001 add,010 sll,011 srl,100 sub,101 slt,110 abs,111 seq)
//  r0_rs_i          in   8  r0 operand rs
//  r0_rt_i          in   8  r0 operand rt
//  r0_rsp_valid_o   out  1  r0 response valid
//  r0_rsp_ready_i   in   1  r0 response consumed
//  r1_*             --   -  identical set for requester r1
//  rsp_result_o     out  8  response result (shared by both requesters)
//  rsp_set_o        out  1  response set flag (shared by both requesters)
//  rsp_zero_o       out  1  response zero flag (shared by both requesters)
//  alu_opcode_o     out  3  to ALU opcode_i
//  alu_rs_o         out  8  to ALU rs_i
//  alu_rt_o         out  8  to ALU rt_i
//  alu_result_i     in   8  from ALU alu_result_o
//  alu_set_i        in   1  from ALU set_o
//  alu_zero_i       in   1  from ALU zero
//  busy_o           out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n_i low)
//   - State = IDLE; operand/opcode regs = 0; rsp_result/set/zero = 0; cnt = 0.
//   - owner = 0; last_grant = 1, so r0 wins the first contention.
//   - All *_ready_o, *_rsp_valid_o and busy_o = 0.
//   - Reset mid-operation drops the op silently; no response is produced.
//  FSM
//   IDLE: rx_req_ready_o = (state==IDLE) & grant==x (combinational, same cycle as valid).
//     - Grant: only one valid -> that one.
//     - Both valid -> FIXED_PRIO ? r0 : the requester != last_grant.
//     - On accept: capture opcode/rs/rt; owner = grant; last_grant = grant; cnt = 0; -> EXEC.
//   EXEC: alu_* driven from captured regs; cnt increments each cycle.
//     - When cnt == EXEC_CYCLES-1, latch the masked ALU outputs (below) -> RESP.
//   RESP: owner's rsp_valid_o = 1; outputs held stable while rsp_ready_i = 0.
//     - On rsp_ready_i = 1 -> IDLE.
//     - The next request can be accepted no earlier than the following cycle (no bypass).
//  alu_* outputs are 0 in IDLE and hold the captured values in EXEC and RESP.
//  Latency: accept at cycle N -> rsp_valid at N+1+EXEC_CYCLES.
//   - Minimum occupancy per op = EXEC_CYCLES+2 cycles.
//  Output masking (removes ALU stale-flag behaviour):
//   - opcode 101: result = 0, set = alu_set_i, zero = 0.
//   - opcode 111: result = 0, set = 0, zero = alu_zero_i.
//   - all other opcodes: result = alu_result_i, set = 0, zero = 0.
//  rsp_result/set/zero_o hold their last latched value outside RESP; consumers must qualify with rsp_valid.
//  Requests arriving during EXEC/RESP see ready=0 and must hold valid and operands until accepted.
//  The non-owner's rsp_valid_o is always 0.
//  Only the owner's rsp_ready_i is observed; the other rsp_ready_i is ignored.
// TESTING
//  - Reset: rst_n_i low mid-EXEC -> all outputs 0 immediately (async); no rsp_valid follows release.
//  - Single op, r0 add rs=8'h3C rt=8'h05, EXEC_CYCLES=1, rsp_ready=1:
//    ready at N, r0_rsp_valid at N+2, result 8'h41, set 0, zero 0; alu_opcode_o = 3'b001 during EXEC.
//  - Contention, round-robin, r0 and r1 valid continuously:
//    grants r0, r1, r0, r1; with FIXED_PRIO=1 -> r0 every time, r1 starved.
//  - Backpressure, r1 slt rs=2 rt=7, rsp_ready low 5 cycles:
//    rsp_valid and outputs stable for 5 cycles; r0 ready stays 0 until handoff; set 1, result 0.
//  - Masking, seq with rs=rt=8'h55 -> zero 1, result 0, set 0.
//    Then and 8'hFF, 8'h01 -> zero 0, set 0 (no stale zero flag).
//  - EXEC_CYCLES=3: rsp_valid exactly 4 cycles after accept; alu_rs_o/alu_rt_o constant across EXEC.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational 8-bit ALU between two valid/ready requesters.
// One op is in flight at a time: accept -> hold ALU inputs for EXEC_CYCLES ->
// latch masked result/flags -> hand the response back to the owner.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1,    // 1..15
  parameter bit          FIXED_PRIO  = 1'b0  // 1: r0 always wins contention
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  // requester 0
  input  logic       r0_req_valid_i,
  output logic       r0_req_ready_o,
  input  logic [2:0] r0_opcode_i,
  input  logic [7:0] r0_rs_i,
  input  logic [7:0] r0_rt_i,
  output logic       r0_rsp_valid_o,
  input  logic       r0_rsp_ready_i,
  // requester 1
  input  logic       r1_req_valid_i,
  output logic       r1_req_ready_o,
  input  logic [2:0] r1_opcode_i,
  input  logic [7:0] r1_rs_i,
  input  logic [7:0] r1_rt_i,
  output logic       r1_rsp_valid_o,
  input  logic       r1_rsp_ready_i,
  // shared response payload
  output logic [7:0] rsp_result_o,
  output logic       rsp_set_o,
  output logic       rsp_zero_o,
  // ALU side
  output logic [2:0] alu_opcode_o,
  output logic [7:0] alu_rs_o,
  output logic [7:0] alu_rt_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_set_i,
  input  logic       alu_zero_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_SEQ   = 3'b111;
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic [2:0] r_opcode;
  logic [7:0] r_rs, r_rt;
  logic       r_owner, r_last_grant;
  logic [7:0] r_result;
  logic       r_set, r_zero;

  logic [1:0] w_req_vld;
  logic       w_grant;
  logic       w_accept;
  logic       w_latch;
  logic       w_owner_rdy;
  logic [2:0] w_sel_opcode;
  logic [7:0] w_sel_rs, w_sel_rt;
  logic [7:0] w_m_result;
  logic       w_m_set, w_m_zero;

  assign w_req_vld   = {r1_req_valid_i, r0_req_valid_i};
  assign w_owner_rdy = r_owner ? r1_rsp_ready_i : r0_rsp_ready_i;

  // Grant select: a lone requester wins; on contention r0 (fixed) or the one not served last.
  always_comb begin
    w_grant = 1'b0;
    if (w_req_vld == 2'b10)      w_grant = 1'b1;
    else if (w_req_vld == 2'b11) w_grant = FIXED_PRIO ? 1'b0 : ~r_last_grant;
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_sel_opcode = r0_opcode_i;
    w_sel_rs     = r0_rs_i;
    w_sel_rt     = r0_rt_i;
    if (w_grant) begin
      w_sel_opcode = r1_opcode_i;
      w_sel_rs     = r1_rs_i;
      w_sel_rt     = r1_rt_i;
    end
  end

  // Next state plus accept/latch strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == LAST_CNT) begin
          w_latch     = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_owner_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The ALU leaves stale flags around; keep only the one field each opcode defines.
  always_comb begin
    w_m_result = alu_result_i;
    w_m_set    = 1'b0;
    w_m_zero   = 1'b0;
    case (r_opcode)
      OP_SLT: begin
        w_m_result = '0;
        w_m_set    = alu_set_i;
      end
      OP_SEQ: begin
        w_m_result = '0;
        w_m_zero   = alu_zero_i;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Settle counter: cleared on accept, counts EXEC cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              r_cnt <= '0;
    else if (w_accept)         r_cnt <= '0;
    else if (r_state == EXEC)  r_cnt <= r_cnt + 4'd1;
  end

  // Capture the granted request and remember who was served for round-robin.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_opcode     <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_opcode     <= w_sel_opcode;
      r_rs         <= w_sel_rs;
      r_rt         <= w_sel_rt;
      r_owner      <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  // Response payload: latched on the last EXEC cycle, held until the next latch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_result <= '0;
      r_set    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_latch) begin
      r_result <= w_m_result;
      r_set    <= w_m_set;
      r_zero   <= w_m_zero;
    end
  end

  // Ready is gated by reset so nothing reads as accepted while held in reset.
  assign r0_req_ready_o = rst_n_i & (r_state == IDLE) & r0_req_valid_i & ~w_grant;
  assign r1_req_ready_o = rst_n_i & (r_state == IDLE) & r1_req_valid_i &  w_grant;

  assign r0_rsp_valid_o = (r_state == RESP) & ~r_owner;
  assign r1_rsp_valid_o = (r_state == RESP) &  r_owner;

  assign rsp_result_o = r_result;
  assign rsp_set_o    = r_set;
  assign rsp_zero_o   = r_zero;

  assign alu_opcode_o = (r_state == IDLE) ? 3'b000 : r_opcode;
  assign alu_rs_o     = (r_state == IDLE) ? 8'h00  : r_rs;
  assign alu_rt_o     = (r_state == IDLE) ? 8'h00  : r_rt;

  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: three arbiter instances (EC=1 RR, EC=1 fixed prio, EC=3 RR)
// share one directed op program; each has its own requester driver, ALU model
// and a cycle-level reference model compared every cycle.
module tb_alu_arbiter;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] rs;
    logic [7:0] rt;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  op_t  prog [2][8];
  int   avail [2];
  logic rrdy [2];
  logic [2:0] all_done;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h at cycle %0d", name, k, act, exp, cyc);
    end
  endtask

  // Raw external ALU behaviour (result only; flags handled separately).
  function automatic logic [7:0] alu_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a + b;
      3'b010:  return a << b[2:0];
      3'b011:  return a >> b[2:0];
      3'b100:  return a - b;
      3'b101:  return 8'hA5;
      3'b110:  return a[7] ? 8'(8'd0 - a) : a;
      default: return 8'h5A;
    endcase
  endfunction

  // What the response must be for an op: {result, set, zero}.
  function automatic logic [9:0] expect_rsp(input op_t o);
    case (o.op)
      3'b101:  return {8'h00, ($signed(o.rs) < $signed(o.rt)), 1'b0};
      3'b111:  return {8'h00, 1'b0, (o.rs == o.rt)};
      default: return {alu_res(o.op, o.rs, o.rt), 2'b00};
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_i
    localparam int EC = (k == 2) ? 3 : 1;
    localparam int FP = (k == 1) ? 1 : 0;

    logic v [2];
    op_t  cur [2];
    logic r0_rdy, r1_rdy, r0_rv, r1_rv;
    logic [7:0] res;
    logic set, zero, busy;
    logic [2:0] aop;
    logic [7:0] ars, art, ares;
    logic aset, azero;

    // ALU model with deliberately stale-looking flags on every opcode.
    assign ares  = alu_res(aop, ars, art);
    assign aset  = ($signed(ars) < $signed(art)) | ((aop != 3'b101) & art[0]);
    assign azero = (ars == art) | ((aop != 3'b111) & ars[0]);

    alu_arbiter #(.EXEC_CYCLES(EC), .FIXED_PRIO(FP == 1)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .r0_req_valid_i(v[0]), .r0_req_ready_o(r0_rdy),
      .r0_opcode_i(cur[0].op), .r0_rs_i(cur[0].rs), .r0_rt_i(cur[0].rt),
      .r0_rsp_valid_o(r0_rv), .r0_rsp_ready_i(rrdy[0]),
      .r1_req_valid_i(v[1]), .r1_req_ready_o(r1_rdy),
      .r1_opcode_i(cur[1].op), .r1_rs_i(cur[1].rs), .r1_rt_i(cur[1].rt),
      .r1_rsp_valid_o(r1_rv), .r1_rsp_ready_i(rrdy[1]),
      .rsp_result_o(res), .rsp_set_o(set), .rsp_zero_o(zero),
      .alu_opcode_o(aop), .alu_rs_o(ars), .alu_rt_o(art),
      .alu_result_i(ares), .alu_set_i(aset), .alu_zero_i(azero),
      .busy_o(busy)
    );

    // Requester driver: present released ops in order, hold until accepted.
    int   idx [2];
    logic acc [2];
    initial begin
      idx = '{0, 0};
      acc = '{1'b0, 1'b0};
      v   = '{1'b0, 1'b0};
      cur[0] = '0;
      cur[1] = '0;
      forever begin
        @(negedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
          if (acc[r]) idx[r]++;
          v[r]   = (idx[r] < avail[r]);
          cur[r] = prog[r][(idx[r] < 8) ? idx[r] : 7];
        end
        #1;
        acc[0] = v[0] & r0_rdy;
        acc[1] = v[1] & r1_rdy;
      end
    end

    // Reference model: an op accepted in cycle c responds from c+1+EC until the owner takes it.
    logic m_busy;
    int   m_owner, m_last, m_rsp_at;
    op_t  m_op;
    logic [9:0] m_out, m_pend;
    logic glog [16];
    int   gcnt, acc_c, lat;
    logic rv_seen;
    int   hold [2];
    logic [9:0] last_rsp [2];

    assign all_done[k] = (idx[0] == avail[0]) && (idx[1] == avail[1]) && !m_busy;

    initial begin
      logic g0, g1, rv_e;
      m_busy = 1'b0; m_owner = 0; m_last = 1; m_rsp_at = 0;
      m_op = '0; m_out = '0; m_pend = '0;
      gcnt = 0; acc_c = 0; lat = 0; rv_seen = 1'b0;
      hold = '{0, 0};
      last_rsp = '{10'h0, 10'h0};
      for (int i = 0; i < 16; i++) glog[i] = 1'b0;
      forever begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
          m_busy = 1'b0; m_owner = 0; m_last = 1; m_op = '0; m_out = '0;
          chk("rst_ready", k, {r1_rdy, r0_rdy}, 2'b00);
          chk("rst_rspv",  k, {r1_rv, r0_rv}, 2'b00);
          chk("rst_busy",  k, busy, 1'b0);
          chk("rst_alu",   k, {aop, ars, art}, 19'h0);
          chk("rst_rsp",   k, {res, set, zero}, 10'h0);
        end else begin
          if (m_busy && cyc == m_rsp_at) m_out = m_pend;
          g0   = !m_busy && v[0] && (!v[1] || FP == 1 || m_last == 1);
          g1   = !m_busy && v[1] && !g0;
          rv_e = m_busy && (cyc >= m_rsp_at);
          chk("ready", k, {r1_rdy, r0_rdy}, {g1, g0});
          chk("rspv",  k, {r1_rv, r0_rv}, {rv_e && m_owner == 1, rv_e && m_owner == 0});
          chk("busy",  k, busy, m_busy);
          chk("alu",   k, {aop, ars, art}, m_busy ? m_op : 19'h0);
          chk("rsp",   k, {res, set, zero}, m_out);
          // observations used only by the literal checks in the main sequence
          if ((r0_rdy && v[0]) || (r1_rdy && v[1])) begin
            if (gcnt < 16) glog[gcnt] = r1_rdy;
            gcnt++;
            acc_c   = cyc;
            rv_seen = 1'b0;
            hold[r1_rdy ? 1 : 0] = 0;
          end
          if ((r0_rv || r1_rv) && !rv_seen) begin
            lat     = cyc - acc_c;
            rv_seen = 1'b1;
          end
          if (r0_rv) hold[0]++;
          if (r1_rv) hold[1]++;
          if (r0_rv && rrdy[0]) last_rsp[0] = {res, set, zero};
          if (r1_rv && rrdy[1]) last_rsp[1] = {res, set, zero};
          // advance the model across the coming edge
          if (g0 || g1) begin
            m_busy   = 1'b1;
            m_owner  = g0 ? 0 : 1;
            m_last   = m_owner;
            m_op     = cur[m_owner];
            m_rsp_at = cyc + 1 + EC;
            m_pend   = expect_rsp(m_op);
          end else if (rv_e && rrdy[m_owner]) begin
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    #4;
    while (all_done != 3'b111 && n < 300) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("drain", 0, all_done, 3'b111);
    @(negedge clk);
  endtask

  initial begin
    avail = '{0, 0};
    rrdy  = '{1'b1, 1'b1};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) prog[r][i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // contention: both valid continuously from the same cycle
    prog[0][0] = '{3'b001, 8'h10, 8'h20};
    prog[0][1] = '{3'b100, 8'h05, 8'h09};
    prog[0][2] = '{3'b010, 8'h81, 8'h03};
    prog[1][0] = '{3'b011, 8'hF0, 8'h04};
    prog[1][1] = '{3'b110, 8'hF6, 8'h00};
    avail = '{3, 2};
    wait_done();
    chk("rr_order", 0, {g_i[0].glog[0], g_i[0].glog[1], g_i[0].glog[2], g_i[0].glog[3], g_i[0].glog[4]}, 5'b01010);
    chk("fp_order", 1, {g_i[1].glog[0], g_i[1].glog[1], g_i[1].glog[2], g_i[1].glog[3], g_i[1].glog[4]}, 5'b00011);
    chk("rr_order", 2, {g_i[2].glog[0], g_i[2].glog[1], g_i[2].glog[2], g_i[2].glog[3], g_i[2].glog[4]}, 5'b01010);
    chk("abs_res",  0, g_i[0].last_rsp[1], {8'h0A, 2'b00});

    // single op: r0 add 3C + 05
    prog[0][3] = '{3'b001, 8'h3C, 8'h05};
    avail[0] = 4;
    wait_done();
    chk("lat_ec1",  0, g_i[0].lat, 2);
    chk("lat_ec3",  2, g_i[2].lat, 4);
    chk("add_res",  0, g_i[0].last_rsp[0], {8'h41, 2'b00});

    // backpressure: r1 slt 2,7 with rsp_ready low; r0 queued behind it
    rrdy[1] = 1'b0;
    prog[1][2] = '{3'b101, 8'h02, 8'h07};
    avail[1] = 3;
    repeat (3) @(negedge clk);
    prog[0][4] = '{3'b000, 8'h0F, 8'h3C};
    avail[0] = 5;
    repeat (6) @(negedge clk);
    rrdy[1] = 1'b1;
    wait_done();
    chk("slt_rsp",  0, g_i[0].last_rsp[1], {8'h00, 2'b10});
    chk("bp_hold",  0, g_i[0].hold[1], 8);
    chk("bp_hold",  1, g_i[1].hold[1], 8);
    chk("bp_hold",  2, g_i[2].hold[1], 6);
    chk("and_res",  0, g_i[0].last_rsp[0], {8'h0C, 2'b00});

    // masking: seq then and with raw flags set
    prog[0][5] = '{3'b111, 8'h55, 8'h55};
    avail[0] = 6;
    wait_done();
    chk("seq_rsp",  0, g_i[0].last_rsp[0], {8'h00, 2'b01});
    prog[0][6] = '{3'b000, 8'hFF, 8'h01};
    avail[0] = 7;
    wait_done();
    chk("and_nostale", 0, g_i[0].last_rsp[0], {8'h01, 2'b00});

    // reset mid-EXEC on the EC=3 instance
    prog[1][3] = '{3'b001, 8'h11, 8'h22};
    avail[1] = 4;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 2, g_i[2].busy, 1'b1);
    chk("pre_rst_alu",  2, g_i[2].aop, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 2, g_i[2].busy, 1'b0);
    chk("async_alu",  2, {g_i[2].aop, g_i[2].ars, g_i[2].art}, 19'h0);
    chk("async_rsp",  2, {g_i[2].res, g_i[2].set, g_i[2].zero}, 10'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 0, all_done, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
